// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin two-port controller for a registered-input single-port SRAM macro,
// with optional zero-fill of the whole array after reset.
module sram_port_arbiter #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 8,
   parameter bit INIT_ON_RESET = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  p0_req,
   input  logic                  p0_we,
   input  logic [ADDR_WIDTH-1:0] p0_addr,
   input  logic [DATA_WIDTH-1:0] p0_wdata,
   output logic                  p0_gnt,
   output logic                  p0_rsp,
   input  logic                  p1_req,
   input  logic                  p1_we,
   input  logic [ADDR_WIDTH-1:0] p1_addr,
   input  logic [DATA_WIDTH-1:0] p1_wdata,
   output logic                  p1_gnt,
   output logic                  p1_rsp,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  init_done,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   input  logic [DATA_WIDTH-1:0] sram_dout0
);
   localparam logic [1:0] INIT = 2'd0, IDLE = 2'd1, CMD = 2'd2, RESP = 2'd3;
   logic [1:0]          state;
   logic [ADDR_WIDTH:0] cnt;
   logic                owner, is_read, last_grant, sel, open, take;
   // sel picks port 1; on a tie the port that did not win last time goes next
   always_comb begin
      open   = (state == IDLE) || (state == RESP);
      sel    = (p0_req && p1_req) ? !last_grant : p1_req;
      p0_gnt = open && p0_req && !sel;
      p1_gnt = open && p1_req && sel;
      take   = p0_gnt || p1_gnt;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= INIT_ON_RESET ? INIT : IDLE;
         cnt        <= '0;
         sram_csb0  <= 1'b1;
         sram_web0  <= 1'b1;
         sram_addr0 <= '0;
         sram_din0  <= '0;
         p0_rsp     <= 1'b0;
         p1_rsp     <= 1'b0;
         rsp_rdata  <= '0;
         init_done  <= !INIT_ON_RESET;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         is_read    <= 1'b0;
      end else begin
         p0_rsp <= 1'b0;
         p1_rsp <= 1'b0;
         case (state)
            INIT: begin
               if (cnt[ADDR_WIDTH]) begin
                  sram_csb0 <= 1'b1;
                  sram_web0 <= 1'b1;
                  init_done <= 1'b1;
                  state     <= IDLE;
               end else begin
                  sram_csb0  <= 1'b0;
                  sram_web0  <= 1'b0;
                  sram_addr0 <= cnt[ADDR_WIDTH-1:0];
                  sram_din0  <= '0;
                  cnt        <= cnt + 1'b1;
               end
            end
            CMD: begin
               sram_csb0 <= 1'b1;
               sram_web0 <= 1'b1;
               state     <= RESP;
            end
            default: begin
               // dout0 settled after the falling edge inside the CMD->RESP cycle
               if (state == RESP) begin
                  p0_rsp <= !owner;
                  p1_rsp <= owner;
                  if (is_read) rsp_rdata <= sram_dout0;
               end
               if (take) begin
                  sram_csb0  <= 1'b0;
                  sram_web0  <= p1_gnt ? !p1_we : !p0_we;
                  sram_addr0 <= p1_gnt ? p1_addr : p0_addr;
                  sram_din0  <= p1_gnt ? p1_wdata : p0_wdata;
                  owner      <= p1_gnt;
                  is_read    <= p1_gnt ? !p1_we : !p0_we;
                  last_grant <= p1_gnt;
                  state      <= CMD;
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed checks of init fill, latency, round-robin, tie order and reset abort,
// against a small behavioural model of the registered-input SRAM macro.
module tb_sram_port_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        p0_req, p0_we, p1_req, p1_we;
   logic [7:0]  p0_addr, p1_addr;
   logic [31:0] p0_wdata, p1_wdata;
   logic        p0_gnt, p0_rsp, p1_gnt, p1_rsp, init_done;
   logic [31:0] rsp_rdata;
   logic        sram_csb0, sram_web0;
   logic [7:0]  sram_addr0;
   logic [31:0] sram_din0, sram_dout0;
   int          n_chk = 0, n_fail = 0;

   sram_port_arbiter dut (
      .clk(clk), .reset(reset),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_gnt(p0_gnt), .p0_rsp(p0_rsp),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_gnt(p1_gnt), .p1_rsp(p1_rsp),
      .rsp_rdata(rsp_rdata), .init_done(init_done),
      .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
      .sram_din0(sram_din0), .sram_dout0(sram_dout0)
   );

   always #5 clk = ~clk;

   // macro model: inputs sampled at the rising edge, read data appears after the next falling edge
   logic [31:0] mem [256];
   logic        rd_pend = 1'b0;
   logic [7:0]  rd_addr = 8'd0;
   always @(posedge clk) begin
      rd_pend <= !sram_csb0 && sram_web0;
      rd_addr <= sram_addr0;
      if (!sram_csb0 && !sram_web0) mem[sram_addr0] <= sram_din0;
   end
   always @(negedge clk) if (rd_pend) sram_dout0 <= mem[rd_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // single-requester access from IDLE, checking grant, pin capture and 2-cycle response latency
   task automatic do_req(input bit p, input logic we, input logic [7:0] a,
                         input logic [31:0] d, input logic [31:0] exp);
      if (p) begin p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d; end
      else begin p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d; end
      #1;
      chk("gnt", {31'd0, p ? p1_gnt : p0_gnt}, 32'd1);
      @(posedge clk); #1;
      p0_req = 1'b0; p1_req = 1'b0;
      chk("cmd_pins", {22'd0, sram_csb0, sram_web0, sram_addr0}, {22'd0, 1'b0, !we, a});
      @(posedge clk); #1;
      chk("rsp_early", {30'd0, p0_rsp, p1_rsp}, 32'd0);
      @(posedge clk); #1;
      chk("rsp", {30'd0, p0_rsp, p1_rsp}, p ? 32'd1 : 32'd2);
      chk("rdata", rsp_rdata, exp);
   endtask

   initial begin
      reset = 1'b1;
      p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
      p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
      sram_dout0 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pins", {sram_csb0, sram_web0, sram_addr0, 22'd0}, {1'b1, 1'b1, 8'd0, 22'd0});
      chk("rst_din", sram_din0, 32'd0);
      chk("rst_flags", {28'd0, init_done, p0_rsp, p1_rsp, p0_gnt}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 256; i++) begin
         @(posedge clk); #1;
         chk("init_pins", {13'd0, init_done, sram_csb0, sram_web0, sram_din0[7:0], sram_addr0},
             {24'd0, i[7:0]});
      end
      @(posedge clk); #1;
      chk("init_done", {30'd0, init_done, sram_csb0}, 32'd3);
      do_req(1'b0, 1'b0, 8'hA5, 32'd0, 32'd0);
      do_req(1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 32'd0);
      do_req(1'b0, 1'b0, 8'h10, 32'd0, 32'hDEADBEEF);
      do_req(1'b0, 1'b1, 8'h01, 32'h11111111, 32'hDEADBEEF);
      do_req(1'b1, 1'b1, 8'h02, 32'h22222222, 32'hDEADBEEF);
      // both ports stream reads; last winner was p1 so p0 leads
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h01;
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h02;
      for (int k = 0; k < 6; k++) begin
         #0;
         chk("rr_gnt", {30'd0, p0_gnt, p1_gnt}, (k % 2) ? 32'd1 : 32'd2);
         @(posedge clk); #1;
         chk("rr_cmd_gnt", {30'd0, p0_gnt, p1_gnt}, 32'd0);
         if (k > 0) begin
            chk("rr_rsp", {30'd0, p0_rsp, p1_rsp}, ((k - 1) % 2) ? 32'd1 : 32'd2);
            chk("rr_rdata", rsp_rdata, ((k - 1) % 2) ? 32'h22222222 : 32'h11111111);
         end
         @(posedge clk); #1;
      end
      p0_req = 1'b0; p1_req = 1'b0;
      @(posedge clk); #1;
      chk("rr_last_rsp", {30'd0, p0_rsp, p1_rsp}, 32'd1);
      chk("rr_last_rdata", rsp_rdata, 32'h22222222);
      // simultaneous p1 write / p0 read of 0xFF: p0 wins and sees the old value
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'hFF;
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 8'hFF; p1_wdata = 32'h12345678;
      #1;
      chk("tie_gnt", {30'd0, p0_gnt, p1_gnt}, 32'd2);
      @(posedge clk); #1;
      p0_req = 1'b0;
      @(posedge clk); #1;
      chk("tie_p1_gnt", {30'd0, p0_gnt, p1_gnt}, 32'd1);
      @(posedge clk); #1;
      p1_req = 1'b0;
      chk("tie_p0_rsp", {30'd0, p0_rsp, p1_rsp}, 32'd2);
      chk("tie_old", rsp_rdata, 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("tie_p1_rsp", {30'd0, p0_rsp, p1_rsp}, 32'd1);
      chk("tie_hold", rsp_rdata, 32'd0);
      do_req(1'b0, 1'b0, 8'hFF, 32'd0, 32'h12345678);
      // p1 read aborted by reset in CMD, then p0 raises a request during the refill
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h02;
      #1;
      chk("abort_gnt", {31'd0, p1_gnt}, 32'd1);
      @(posedge clk); #1;
      p1_req = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort_pins", {29'd0, sram_csb0, init_done, p1_rsp}, 32'd4);
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h10;
      for (int i = 0; i < 256; i++) begin
         @(posedge clk); #1;
         chk("reinit_pins", {21'd0, p0_gnt, p1_rsp, sram_csb0, sram_addr0}, {24'd0, i[7:0]});
      end
      @(posedge clk); #1;
      chk("reinit_done", {30'd0, init_done, p0_gnt}, 32'd3);
      @(posedge clk); #1;
      p0_req = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("reinit_rsp", {30'd0, p0_rsp, p1_rsp}, 32'd2);
      chk("reinit_rdata", rsp_rdata, 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Two-requester controller for the 32x256 single-port OpenRAM macro `sram_32_256_sky130A`.
- Arbitrates read/write requests round-robin and drives the macro's registered-input port (csb0/web0/addr0/din0).
- Samples dout0 at the correct edge and returns read data to the winning requester.
- Optionally zero-fills the whole array after reset before accepting traffic. Sits between the core's instruction/data paths and the SRAM macro.

Parameters:
- DATA_WIDTH, 32, word width (must match macro)
- ADDR_WIDTH, 8, word address width; depth = 1<<ADDR_WIDTH
- INIT_ON_RESET, 1, 1 = zero-fill all words after reset; 0 = go straight to IDLE

Ports:
- clk  input  1  clock; also drives macro clk0
- reset  input  1  synchronous, active-high reset
- p0_req  input  1  port 0 request; held with fields stable until granted
- p0_we  input  1  port 0 write enable (1 = write)
- p0_addr  input  ADDR_WIDTH  port 0 word address
- p0_wdata  input  DATA_WIDTH  port 0 write data
- p0_gnt  output  1  port 0 request accepted at this rising edge
- p0_rsp  output  1  one-cycle completion pulse for port 0 (read data valid or write done)
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rsp  same as port 0, for port 1
- rsp_rdata  output  DATA_WIDTH  read data; valid while p0_rsp or p1_rsp is high for a read
- init_done  output  1  high once zero-fill is complete (or immediately after reset if INIT_ON_RESET=0)
- sram_csb0  output  1  macro chip select, active low, registered
- sram_web0  output  1  macro write enable, active low, registered
- sram_addr0  output  ADDR_WIDTH  macro address, registered
- sram_din0  output  DATA_WIDTH  macro write data, registered
- sram_dout0  input  DATA_WIDTH  macro read data

Behaviour:
- Interface:
  - One clock, clk. Reset is synchronous and active-high (reset).
  - All outputs except p0_gnt and p1_gnt are registered.
- Reset values:
  - sram_csb0=1, sram_web0=1, sram_addr0=0, sram_din0=0.
  - p0_rsp=p1_rsp=0, rsp_rdata=0, init_done=0.
  - last_grant=1, so port 0 wins the first tie.
  - State = INIT if INIT_ON_RESET, else IDLE.
- State machine:
  - INIT, CMD and RESP each form a one-cycle macro transaction: the controller drives the registered pins, the macro samples them at the next edge and updates dout0 after the following falling edge.
  - INIT:
    - Drives csb0=0, web0=0, din0=0, addr0=counter, one word per cycle.
    - After addr 255 has been presented, csb0 returns to 1, init_done is set and state becomes IDLE.
    - gnt stays 0 throughout INIT; elapsed time is 256 cycles plus 1 cycle.
  - IDLE:
    - gnt is combinational, asserted for the arbiter winner when any req is high.
    - On the edge with req&gnt: capture we/addr/wdata into sram_* (csb0=0), record the owner and whether it is a read, update last_grant, go to CMD.
  - CMD:
    - The macro samples inputs at this cycle's closing edge.
    - At that edge set csb0=1, web0=1 and go to RESP.
    - No grant is issued in CMD.
  - RESP:
    - At the closing edge: load rsp_rdata from sram_dout0 if the access is a read (hold the previous value for a write), and pulse the owner's rsp for the following cycle.
    - Also at that edge, gnt may be issued; a new acceptance loads sram_* and goes to CMD. Otherwise go to IDLE.
    - Sustained throughput is 1 access per 2 cycles.
- Latency: with acceptance at edge E0, the macro samples at E1 and rsp is high in the cycle after E2. Reads and writes have identical latency.
- Arbitration:
  - Round-robin.
  - When both ports request, grant the port not equal to last_grant.
  - A single requester always wins.
  - At most one gnt per cycle.
- Write-then-read to the same address from either port returns the new data; the ordering is strict because only one access is outstanding.
- Reset mid-operation: any outstanding access is dropped with no rsp pulse. csb0=1 in the first cycle after reset and INIT restarts at address 0.
- Requests raised during INIT are held off (gnt=0) but not lost.
- Address arithmetic: the init counter is ADDR_WIDTH+1 bits; the terminal condition is when the counter MSB sets.

Test Plan:
- Reset with INIT_ON_RESET=1, no requests:
  - 256 consecutive writes of 0 appear on the sram_* pins, addr 0..255.
  - init_done rises on cycle 257.
  - A subsequent read of addr 0xA5 returns rsp_rdata=0x00000000.
- Port 0 writes 0xDEADBEEF to addr 0x10, then port 0 reads addr 0x10:
  - Each p0_rsp pulse occurs 2 cycles after its gnt.
  - rsp_rdata=0xDEADBEEF.
- Both ports request continuously, p0 reading 0x01 and p1 reading 0x02:
  - Grants alternate p0, p1, p0, ..., one every 2 cycles.
  - rsp_rdata alternates between the stored values.
  - p1 is never starved.
- p1 writes 0x12345678 to addr 0xFF while p0 simultaneously reads 0xFF:
  - p0 wins the first tie and reads the old value (0).
  - p1's write follows; a re-read by p0 returns 0x12345678.
- Assert reset for 1 cycle while in CMD after a p1 read grant:
  - No p1_rsp ever pulses.
  - sram_csb0=1 the next cycle and the INIT sequence restarts from addr 0.
- p0_req asserted during INIT:
  - p0_gnt stays 0 until init_done=1.
  - p0_gnt is then granted in the first IDLE cycle.
